alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Decode-to-execute pipeline register that builds the ALU operand bundle (op1, op2, fun).
//  Resolves RAW hazards by forwarding from EX and WB, and stalls one cycle on load-use.
//  Sits directly upstream of the ALU; its registered outputs drive the ALU input bundle.
//  Valid/ready handshake on both sides; flush input for branch/exception kill.
// PARAMETERS
//  XLEN   32  datapath width (op1/op2/forward data)
//  FUNW   4   ALU function code width
//  REGW   5   register index width; index 0 is hardwired zero
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  reset        in   1     synchronous, active-high reset
//  flush        in   1     kill held instruction and the current input
//  in_valid     in   1     decode presents an instruction
//  in_ready     out  1     stage accepts this cycle (comb)
//  in_pc        in   XLEN  instruction PC
//  in_imm       in   XLEN  sign-extended immediate
//  in_rs1       in   REGW  source 1 index
//  in_rs2       in   REGW  source 2 index
//  in_rs1_data  in   XLEN  regfile read data for rs1
//  in_rs2_data  in   XLEN  regfile read data for rs2
//  in_use_rs1   in   1     instruction reads rs1
//  in_use_rs2   in   1     instruction reads rs2
//  in_op1_sel   in   1     0: rs1 value, 1: pc
//  in_op2_sel   in   1     0: rs2 value, 1: imm
//  in_fun       in   FUNW  ALU function code
//  in_rd        in   REGW  destination index
//  in_wen       in   1     instruction writes rd
//  in_is_load   in   1     instruction is a load (result late)
//  ex_result    in   XLEN  ALU result of the instruction held in this stage
//  wb_valid     in   1     WB stage writes register this cycle
//  wb_rd        in   REGW  WB destination index
//  wb_data      in   XLEN  WB write data
//  out_valid    out  1     ALU bundle valid
//  out_ready    in   1     downstream consumes bundle this cycle
//  out_op1      out  XLEN  ALU operand 1
//  out_op2      out  XLEN  ALU operand 2
//  out_fun      out  FUNW  ALU function code
//  out_rd       out  REGW  destination index
//  out_wen      out  1     destination write enable
//  out_is_load  out  1     held instruction is a load
//  stall_count  out  32    load-use stall cycles since reset, saturates at 2^32-1
// BEHAVIOUR
//  - Reset: out_valid=0; out_op1/out_op2=0; out_fun/out_rd=0; out_wen=0; out_is_load=0;
//    stall_count=0. in_ready is combinational (=0 while reset is high).
//  - Source value, per rs:
//    - rs==0 -> 0.
//    - elif out_valid & out_wen & !out_is_load & out_rd==rs -> ex_result (EX fwd).
//    - elif wb_valid & wb_rd==rs -> wb_data.
//    - else regfile data. EX has priority over WB; rd 0 is never forwarded.
//  - hazard = out_valid & out_is_load & out_wen & out_rd!=0 & in_valid &
//    ((in_use_rs1 & in_rs1==out_rd) | (in_use_rs2 & in_rs2==out_rd)).
//  - advance = !out_valid | out_ready; in_ready = advance & !hazard & !flush.
//  - Accept (in_valid & in_ready): register all out_* fields next edge; out_valid=1;
//    op1 = op1_sel ? pc : rs1 value; op2 = op2_sel ? imm : rs2 value. Latency 1 cycle.
//  - advance & hazard: bubble inserted (out_valid<=0, fields hold). stall_count+1.
//  - advance & !in_valid: out_valid<=0.
//  - !advance: all out_* hold unchanged (stable under backpressure).
//  - flush: highest priority after reset; out_valid<=0 next edge, input not accepted,
//    stall_count unchanged.
//  - Load in EX never forwarded from ex_result; the value arrives via wb_* after the stall.
//  - Arithmetic: no width changes; operands pass through unmodified at XLEN.
// TESTING
//  - rs1=x5, rs2=x6, regfile 0x11/0x22, no fwd, fun=ADD -> next cycle op1=0x11, op2=0x22, valid=1.
//  - EX holds wen rd=x5=0x100; WB rd=x5=0x200 -> op1=0x100 (EX wins); EX rd=0 -> 0x200.
//  - Load rd=x7 held; next instr uses rs2=x7 -> in_ready=0 one cycle, bubble out, stall_count=1;
//    then wb x7=0xABC -> op2=0xABC.
//  - out_ready=0 for 3 cycles with valid bundle -> out_* identical all 3 cycles, in_ready=0.
//  - flush with in_valid=1 and valid held -> next cycle out_valid=0; instruction dropped.
//  - in_rs1=0 while WB writes rd=0 data 0xFFFF -> op1=0; op1_sel=1, pc=0x80 -> op1=0x80.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute register that builds the ALU operand bundle.
// Each source operand is forwarded from EX and WB. A load sitting in EX makes a
// dependent instruction wait for one cycle, because a load result cannot be
// forwarded from ex_result; its value reaches this stage later through wb_*.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int FUNW = 4,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic            in_op1_sel,
    input  logic            in_op2_sel,
    input  logic [FUNW-1:0] in_fun,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_wen,
    input  logic            in_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wb_valid,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [FUNW-1:0] out_fun,
    output logic [REGW-1:0] out_rd,
    output logic            out_wen,
    output logic            out_is_load,
    output logic [31:0]     stall_count
);

    logic            out_valid_q,   out_valid_d;
    logic [XLEN-1:0] out_op1_q,     out_op1_d;
    logic [XLEN-1:0] out_op2_q,     out_op2_d;
    logic [FUNW-1:0] out_fun_q,     out_fun_d;
    logic [REGW-1:0] out_rd_q,      out_rd_d;
    logic            out_wen_q,     out_wen_d;
    logic            out_is_load_q, out_is_load_d;
    logic [31:0]     stall_count_q, stall_count_d;

    logic            ex_fwd_ok;
    logic            load_in_ex;
    logic            hazard;
    logic            advance;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // The held instruction can forward only if it is a valid non-load that writes a register
    assign ex_fwd_ok  = out_valid_q & out_wen_q & ~out_is_load_q;
    assign load_in_ex = out_valid_q & out_is_load_q & out_wen_q & (out_rd_q != '0);

    // Operand resolution: x0 is always zero, EX has priority over WB, otherwise use the regfile
    always_comb begin
        rs1_val = in_rs1_data;
        if (in_rs1 == '0) begin
            rs1_val = '0;
        end else if (ex_fwd_ok && (out_rd_q == in_rs1)) begin
            rs1_val = ex_result;
        end else if (wb_valid && (wb_rd == in_rs1)) begin
            rs1_val = wb_data;
        end

        rs2_val = in_rs2_data;
        if (in_rs2 == '0) begin
            rs2_val = '0;
        end else if (ex_fwd_ok && (out_rd_q == in_rs2)) begin
            rs2_val = ex_result;
        end else if (wb_valid && (wb_rd == in_rs2)) begin
            rs2_val = wb_data;
        end
    end

    assign hazard   = load_in_ex & in_valid &
                      ((in_use_rs1 & (in_rs1 == out_rd_q)) |
                       (in_use_rs2 & (in_rs2 == out_rd_q)));
    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance & ~hazard & ~flush & ~reset;
    assign accept   = in_valid & in_ready;

    // Next bundle: a flush kills the held instruction, a hazard inserts a bubble, backpressure holds the bundle
    always_comb begin
        out_valid_d   = out_valid_q;
        out_op1_d     = out_op1_q;
        out_op2_d     = out_op2_q;
        out_fun_d     = out_fun_q;
        out_rd_d      = out_rd_q;
        out_wen_d     = out_wen_q;
        out_is_load_d = out_is_load_q;
        stall_count_d = stall_count_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            if (hazard) begin
                out_valid_d = 1'b0;
                if (stall_count_q != '1) begin
                    stall_count_d = stall_count_q + 32'd1;
                end
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_op1_d     = in_op1_sel ? in_pc  : rs1_val;
                out_op2_d     = in_op2_sel ? in_imm : rs2_val;
                out_fun_d     = in_fun;
                out_rd_d      = in_rd;
                out_wen_d     = in_wen;
                out_is_load_d = in_is_load;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_fun_q     <= '0;
            out_rd_q      <= '0;
            out_wen_q     <= 1'b0;
            out_is_load_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_fun_q     <= out_fun_d;
            out_rd_q      <= out_rd_d;
            out_wen_q     <= out_wen_d;
            out_is_load_q <= out_is_load_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op1     = out_op1_q;
    assign out_op2     = out_op2_q;
    assign out_fun     = out_fun_q;
    assign out_rd      = out_rd_q;
    assign out_wen     = out_wen_q;
    assign out_is_load = out_is_load_q;
    assign stall_count = stall_count_q;

endmodule
